// File: rtl/dec_seq_ctrl_if.sv
// dec_seq_ctrl_if: upstream and downstream valid/ready handshakes of the decoder sequencer.
//   in_valid / in_ready / in_codeword            codeword accepted from upstream
//   out_valid / out_ready / out_data /
//   out_num_of_errors                            decoded result presented downstream
// Modports: master = traffic source/sink (upstream producer + downstream consumer),
//           slave  = the sequencer itself.
interface dec_seq_ctrl_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_codeword;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_num_of_errors;

    modport master (
        output in_valid,
        output in_codeword,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_num_of_errors
    );

    modport slave (
        input  in_valid,
        input  in_codeword,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_num_of_errors
    );
endinterface

// File: rtl/dec_seq_ctrl.sv
// dec_seq_ctrl: sequencer in front of the decoder core.
//   Accepts one codeword per in_valid/in_ready handshake, holds it on core_codeword_o,
//   waits CORE_LAT cycles, captures the core's corrected data and error class, then
//   presents the result on an out_valid/out_ready handshake.
// Ports:
//   clk_i                 clock, all state on the rising edge
//   rst_ni                asynchronous active-low reset
//   bus_io                upstream/downstream handshakes (dec_seq_ctrl_if.slave)
//   core_codeword_o       registered codeword driven into the decoder core
//   core_num_of_errors_i  core class: 00 none, 01 single fixed, 1x uncorrectable
//   core_data_out_i       core corrected data
//   busy_o                high whenever a word is in flight
//   cnt_clr_i             synchronous clear of the statistics counters
//   cnt_single_o          corrected-word count (saturating)
//   cnt_multi_o           uncorrectable-word count (saturating)
// Configuration: define DEC_STATS_EN to build the statistics counters; otherwise
//   cnt_clr_i is ignored and both counter outputs are tied to zero.
module dec_seq_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CORE_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dec_seq_ctrl_if.slave     bus_io,
    output logic [DATA_W-1:0] core_codeword_o,
    input  logic [1:0]        core_num_of_errors_i,
    input  logic [DATA_W-1:0] core_data_out_i,
    output logic              busy_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  cnt_single_o,
    output logic [CNT_W-1:0]  cnt_multi_o
);
    localparam int unsigned     LatW    = $clog2(CORE_LAT + 1);
    localparam logic [LatW-1:0] LatLoad = LatW'(CORE_LAT);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e            state_q;
    logic [LatW-1:0]   wait_cnt_q;
    logic [DATA_W-1:0] core_cw_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_err_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_err;

    // Classes 10 and 11 are both uncorrectable: report 10 and never pass core data through.
    always_comb begin
        res_err  = core_num_of_errors_i;
        res_data = core_data_out_i;
        if (core_num_of_errors_i[1]) begin
            res_err  = 2'b10;
            res_data = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            core_cw_q   <= '0;
            out_data_q  <= '0;
            out_err_q   <= 2'b00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        core_cw_q  <= bus_io.in_codeword;
                        wait_cnt_q <= LatLoad;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - LatW'(1);
                    // Last wait cycle: core outputs for core_cw_q are valid at this edge.
                    if (wait_cnt_q == LatW'(1)) begin
                        out_data_q  <= res_data;
                        out_err_q   <= res_err;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.in_ready          = in_ready_q;
    assign bus_io.out_valid         = out_valid_q;
    assign bus_io.out_data          = out_data_q;
    assign bus_io.out_num_of_errors = out_err_q;
    assign core_codeword_o          = core_cw_q;
    assign busy_o                   = busy_q;

`ifdef DEC_STATS_EN
    logic             out_hs;
    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0] cnt_multi_q, cnt_multi_d;

    assign out_hs = out_valid_q & bus_io.out_ready;

    // Clear has priority over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_multi_d  = cnt_multi_q;
        if (cnt_clr_i) begin
            cnt_single_d = '0;
            cnt_multi_d  = '0;
        end else if (out_hs) begin
            if (out_err_q == 2'b01 && cnt_single_q != '1) begin
                cnt_single_d = cnt_single_q + CNT_W'(1);
            end
            if (out_err_q == 2'b10 && cnt_multi_q != '1) begin
                cnt_multi_d = cnt_multi_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_single_q <= '0;
            cnt_multi_q  <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_multi_q  <= cnt_multi_d;
        end
    end

    assign cnt_single_o = cnt_single_q;
    assign cnt_multi_o  = cnt_multi_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign cnt_single_o   = '0;
    assign cnt_multi_o    = '0;
`endif

endmodule
